// File: rtl/serial_tx_pkg.sv
// Shared encodings for the serial bit-stream transmitter.
// Combinational constants only; no latency.
// No flow control.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Sent bit 0 first; two equal bits mark a frame start downstream.
    localparam logic [1:0] PRE_PATTERN = 2'b11;
    localparam int         PRE_LEN     = 2;

endpackage

// File: rtl/serial_bit_counter.sv
// Cycle counter with synchronous clear/enable; tc flags the MAX-th counted cycle.
// tc is combinational from the count register.
// No flow control.
module serial_bit_counter #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // One spare code so the count can sit at MAX after the final cycle.
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(MAX - 1));

endmodule

// File: rtl/serial_seq_tx.sv
// Word-to-serial transmitter, LSB first, GAP idle cycles per frame; SERIAL_SEQ_TX_PREAMBLE_EN adds a 2-bit 11 preamble.
// din[0] on outp 1 cycle after handshake (+2 with preamble); frame spacing WIDTH+GAP+1 (+2).
// din_ready high only in IDLE; din_valid/din ignored elsewhere.
module serial_seq_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             outp,
    output logic             outp_valid,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sreg;
    logic             hs;
    logic             shift_tc;
    logic             gap_tc;
    logic             outp_d;
    logic             outp_valid_d;
    logic             done_d;
    logic             din_ready_d;

    assign hs = (state == ST_IDLE) && din_ready && din_valid;

    serial_bit_counter #(.MAX(WIDTH)) u_shift_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hs),
        .en    (state == ST_SHIFT),
        .tc    (shift_tc)
    );

    generate
        if (GAP > 0) begin : g_gap
            serial_bit_counter #(.MAX(GAP)) u_gap_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (state != ST_GAP),
                .en    (state == ST_GAP),
                .tc    (gap_tc)
            );
        end else begin : g_nogap
            assign gap_tc = 1'b1;
        end
    endgenerate

`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
    logic pre_tc;

    serial_bit_counter #(.MAX(PRE_LEN)) u_pre_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_PRE),
        .en    (state == ST_PRE),
        .tc    (pre_tc)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (hs) begin
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
                    next_state = ST_PRE;
`else
                    next_state = ST_SHIFT;
`endif
                end
            end
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
            ST_PRE: begin
                if (pre_tc) next_state = ST_SHIFT;
            end
`endif
            ST_SHIFT: begin
                if (shift_tc) next_state = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_tc) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; ready follows the state we are about to enter.
    always_comb begin
        outp_d       = 1'b0;
        outp_valid_d = 1'b0;
        done_d       = 1'b0;
        din_ready_d  = (next_state == ST_IDLE);
        case (state)
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
            ST_PRE: begin
                outp_d       = pre_tc ? PRE_PATTERN[1] : PRE_PATTERN[0];
                outp_valid_d = 1'b1;
            end
`endif
            ST_SHIFT: begin
                outp_d       = sreg[0];
                outp_valid_d = 1'b1;
                done_d       = shift_tc;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg       <= '0;
            outp       <= 1'b0;
            outp_valid <= 1'b0;
            done       <= 1'b0;
            din_ready  <= 1'b0;
        end else begin
            outp       <= outp_d;
            outp_valid <= outp_valid_d;
            done       <= done_d;
            din_ready  <= din_ready_d;
            if (hs) begin
                sreg <= din;
            end else if (state == ST_SHIFT) begin
                sreg <= sreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: table-driven frames, hand-written corner sequences, random scoreboard.
// Build with SERIAL_SEQ_TX_PREAMBLE_EN defined to exercise the preamble variant.
module tb_serial_seq_tx;

    localparam int WIDTH = 16;
    localparam int GAP   = 2;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
    localparam int PRE_BITS = 2;
`else
    localparam int PRE_BITS = 0;
`endif
    localparam int FRAME = PRE_BITS + WIDTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        outp;
    logic        outp_valid;
    logic        done;

    int errors = 0;
    int checks = 0;

    serial_seq_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .outp       (outp),
        .outp_valid (outp_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        repeat (3) begin
            tick();
            check1("rst_outp", outp, 1'b0);
            check1("rst_outp_valid", outp_valid, 1'b0);
            check1("rst_done", done, 1'b0);
            check1("rst_din_ready", din_ready, 1'b0);
        end
        rst_n = 1'b1;
        check1("release_ready_early", din_ready, 1'b0);
        tick();
        check1("release_ready", din_ready, 1'b1);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 40 && din_ready !== 1'b1; n++) tick();
        check1("ready_wait", din_ready, 1'b1);
    endtask

    // seq holds the expected serial bits in send order, first bit at [15].
    task automatic send(input logic [15:0] word, input logic [15:0] seq);
        wait_ready();
        din       = word;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 16'($urandom);
        check1("hs_ready_drop", din_ready, 1'b0);
        check1("hs_valid_low", outp_valid, 1'b0);
        for (int i = 0; i < PRE_BITS; i++) begin
            tick();
            check1("pre_outp", outp, 1'b1);
            check1("pre_valid", outp_valid, 1'b1);
            check1("pre_done", done, 1'b0);
        end
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            check1("bit_outp", outp, seq[15-i]);
            check1("bit_valid", outp_valid, 1'b1);
            check1("bit_done", done, i == WIDTH - 1);
            check1("bit_ready", din_ready, 1'b0);
        end
        for (int g = 0; g < GAP; g++) begin
            tick();
            check1("gap_outp", outp, 1'b0);
            check1("gap_valid", outp_valid, 1'b0);
            check1("gap_done", done, 1'b0);
            check1("gap_ready", din_ready, g == GAP - 1);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] seq;
    } vec_t;

    typedef struct {
        logic b;
        logic v;
        logic d;
    } ent_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{word: 16'h5772, seq: 16'b0100_1110_1110_1010};
        vecs[1] = '{word: 16'hFFFF, seq: 16'b1111_1111_1111_1111};
        vecs[2] = '{word: 16'h0000, seq: 16'b0000_0000_0000_0000};
        vecs[3] = '{word: 16'h0001, seq: 16'b1000_0000_0000_0000};
        vecs[4] = '{word: 16'h8000, seq: 16'b0000_0000_0000_0001};
        vecs[5] = '{word: 16'h1234, seq: 16'b0010_1100_0100_1000};

        do_reset();

        for (int k = 0; k < 6; k++) send(vecs[k].word, vecs[k].seq);

        // Back-to-back with din_valid held: FFFF then 0000.
        begin
            int base2;
            logic in1, in2, eo, ev, ed, er;
            base2 = FRAME + GAP + 1;
            wait_ready();
            din       = 16'hFFFF;
            din_valid = 1'b1;
            tick();
            din = 16'h0000;
            for (int c = 1; c <= base2 + FRAME + GAP + 2; c++) begin
                tick();
                in1 = (c <= FRAME);
                in2 = (c > base2) && (c <= base2 + FRAME);
                ev  = in1 || in2;
                eo  = in1 || (in2 && (c - base2 <= PRE_BITS));
                ed  = (c == FRAME) || (c == base2 + FRAME);
                er  = (c == FRAME + GAP) || (c >= base2 + FRAME + GAP);
                check4("b2b", {outp, outp_valid, done, din_ready}, {eo, ev, ed, er});
                if (c == base2) din_valid = 1'b0;
            end
        end

        // Async reset on the 7th data bit of AAAA, then a clean frame.
        wait_ready();
        din       = 16'hAAAA;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (PRE_BITS + 7) tick();
        check1("mid_valid_before", outp_valid, 1'b1);
        check1("mid_outp_before", outp, 1'b0);
        rst_n = 1'b0;
        #1;
        check1("async_outp", outp, 1'b0);
        check1("async_valid", outp_valid, 1'b0);
        check1("async_done", done, 1'b0);
        check1("async_ready", din_ready, 1'b0);
        do_reset();
        send(16'h0001, 16'b1000_0000_0000_0000);

        // Random scoreboard plus a two-equal-bit detector on both streams.
        begin
            ent_t        q[$];
            ent_t        o;
            logic        m_ready;
            logic        v;
            logic [15:0] w;
            logic        ap, ah, ep, eh, adet, edet;
            int          accepted, cyc;
            do_reset();
            m_ready  = 1'b1;
            accepted = 0;
            cyc      = 0;
            ap = 1'b0; ah = 1'b0; ep = 1'b0; eh = 1'b0;
            while (accepted < 200 && cyc < 20000) begin
                v         = 1'($urandom_range(0, 1));
                w         = 16'($urandom);
                din       = w;
                din_valid = v;
                @(posedge clk);
                cyc++;
                o = '{b: 1'b0, v: 1'b0, d: 1'b0};
                if (q.size() != 0) o = q.pop_front();
                if (m_ready && v) begin
                    accepted++;
                    for (int i = 0; i < PRE_BITS; i++) q.push_back('{b: 1'b1, v: 1'b1, d: 1'b0});
                    for (int i = 0; i < WIDTH; i++) q.push_back('{b: w[i], v: 1'b1, d: (i == WIDTH - 1)});
                    for (int g = 0; g < GAP; g++) q.push_back('{b: 1'b0, v: 1'b0, d: 1'b0});
                end
                m_ready = (q.size() == 0);
                #1;
                check4("rand_out", {outp, outp_valid, done, din_ready}, {o.b, o.v, o.d, m_ready});
                adet = outp_valid && ah && (outp == ap);
                edet = o.v && eh && (o.b == ep);
                check1("rand_det", adet, edet);
                ah = outp_valid; ap = outp;
                eh = o.v;        ep = o.b;
            end
            din_valid = 1'b0;
            checks++;
            if (accepted != 200) begin
                errors++;
                $display("FAIL rand_accept: got %0d words expected 200", accepted);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
